// File: rtl/seq_detector_param.sv
// Serial pattern detector: captures a word on start and scans it MSB-first
// against PATTERN, reporting found, the match count and the first match position.
module seq_detector_param #(
  parameter int              DATA_W  = 8,
  parameter int              PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
  parameter int              CNT_W   = $clog2(DATA_W+1),
  parameter int              POS_W   = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              overlap,
  output logic              busy,
  output logic              done,
  output logic              match_pulse,
  output logic              found,
  output logic [CNT_W-1:0]  match_count,
  output logic [POS_W-1:0]  first_pos
);

  localparam int FILL_W = $clog2(PAT_W+1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [POS_W-1:0]    idx_q, idx_d;
  logic [PAT_W-1:0]    window_q, window_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                ovl_q, ovl_d;
  logic                done_q, done_d;
  logic                mp_q, mp_d;
  logic                found_q, found_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    first_q, first_d;
  logic [PAT_W-1:0]    nw;
  logic                hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      window_q <= '0;
      fill_q   <= '0;
      ovl_q    <= 1'b0;
      done_q   <= 1'b0;
      mp_q     <= 1'b0;
      found_q  <= 1'b0;
      cnt_q    <= '0;
      first_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      window_q <= window_d;
      fill_q   <= fill_d;
      ovl_q    <= ovl_d;
      done_q   <= done_d;
      mp_q     <= mp_d;
      found_q  <= found_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  // A start always wins, even mid-scan, so a restart silently drops the old scan.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    window_d = window_q;
    fill_d   = fill_q;
    ovl_d    = ovl_q;
    done_d   = 1'b0;
    mp_d     = 1'b0;
    found_d  = found_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    nw       = {window_q[PAT_W-2:0], data_q[idx_q]};
    hit      = 1'b0;

    if (start) begin
      state_d  = S_SCAN;
      data_d   = data;
      ovl_d    = overlap;
      idx_d    = POS_W'(DATA_W-1);
      window_d = '0;
      fill_d   = '0;
      found_d  = 1'b0;
      cnt_d    = '0;
      first_d  = '0;
    end else if (state_q == S_SCAN) begin
      window_d = nw;
      fill_d   = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
      hit      = (int'(fill_q) + 1 >= PAT_W) && (nw == PATTERN);
      if (hit) begin
        cnt_d   = cnt_q + 1'b1;
        mp_d    = 1'b1;
        found_d = 1'b1;
        if (!found_q) first_d = idx_q;
        // Non-overlapping mode needs PAT_W fresh bits before the next match.
        if (!ovl_q) fill_d = '0;
      end
      if (idx_q == '0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  assign busy        = (state_q == S_SCAN);
  assign done        = done_q;
  assign match_pulse = mp_q;
  assign found       = found_q;
  assign match_count = cnt_q;
  assign first_pos   = first_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a word-level match model checked every cycle,
// plus directed scans with hand-computed expectations.
module tb_seq_detector_param;

  localparam int              DATA_W  = 8;
  localparam int              PAT_W   = 5;
  localparam logic [PAT_W-1:0] PATTERN = 5'b10010;
  localparam int              CNT_W   = $clog2(DATA_W+1);
  localparam int              POS_W   = $clog2(DATA_W);

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              overlap;
  logic              busy, done, match_pulse, found;
  logic [CNT_W-1:0]  match_count;
  logic [POS_W-1:0]  first_pos;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  seq_detector_param #(
    .DATA_W(DATA_W), .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .overlap(overlap),
    .busy(busy), .done(done), .match_pulse(match_pulse), .found(found),
    .match_count(match_count), .first_pos(first_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // hits[e] is set when the bit presented at scan step e (idx = DATA_W-1-e) ends a match.
  function automatic logic [DATA_W-1:0] find_hits(input logic [DATA_W-1:0] d, input logic ov);
    logic [DATA_W-1:0] hits;
    logic [PAT_W-1:0]  seg;
    int                last_end;
    hits     = '0;
    last_end = -100;
    for (int e = PAT_W-1; e < DATA_W; e++) begin
      seg = PAT_W'(d >> (DATA_W-1-e));
      if (seg == PATTERN && (ov || e - last_end >= PAT_W)) begin
        hits[e]  = 1'b1;
        last_end = e;
      end
    end
    return hits;
  endfunction

  logic              m_busy = 0, m_done = 0, m_mp = 0, m_found = 0;
  int                m_cnt = 0, m_first = 0, m_step = 0;
  logic [DATA_W-1:0] m_hits = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_mp = 0; m_found = 0;
      m_cnt = 0; m_first = 0; m_step = 0;
    end else if (start) begin
      m_hits = find_hits(data, overlap);
      m_busy = 1; m_step = 0; m_done = 0; m_mp = 0;
      m_found = 0; m_cnt = 0; m_first = 0;
    end else if (m_busy) begin
      m_mp = m_hits[m_step];
      if (m_mp) begin
        if (!m_found) m_first = DATA_W-1-m_step;
        m_found = 1;
        m_cnt++;
      end
      m_done = (m_step == DATA_W-1);
      if (m_done) m_busy = 0;
      m_step++;
    end else begin
      m_done = 0;
      m_mp   = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("cyc_busy",        busy,        m_busy);
      check_output("cyc_done",        done,        m_done);
      check_output("cyc_match_pulse", match_pulse, m_mp);
      check_output("cyc_found",       found,       m_found);
      check_output("cyc_match_count", match_count, m_cnt);
      check_output("cyc_first_pos",   first_pos,   m_first);
    end
  end

  task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic ov);
    @(posedge clk); #1;
    start = 1'b1; data = d; overlap = ov;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done; records first match_pulse edge.
  task automatic wait_done(output int done_edge, output int mp_edge, output bit coincide);
    done_edge = -1; mp_edge = -1; coincide = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      else       begin @(posedge clk); #1; end
      if (match_pulse && mp_edge < 0) mp_edge = n;
      if (match_pulse && done) coincide = 1;
      if (done) begin done_edge = n; break; end
    end
    if (done_edge < 0) check_output("done_timeout", 0, 1);
  endtask

  task automatic scan_case(input string name, input logic [DATA_W-1:0] d, input logic ov,
                           input int exp_cnt, input int exp_first, input int exp_mp_edge);
    int de, me; bit co;
    apply_stimulus(d, ov);
    wait_done(de, me, co);
    check_output({name, "_done_edge"}, de, DATA_W);
    check_output({name, "_mp_edge"}, me, exp_mp_edge);
    @(posedge clk); #1;
    check_output({name, "_done_low"}, done, 0);
    check_output({name, "_busy"}, busy, 0);
    check_output({name, "_found"}, found, exp_cnt > 0);
    check_output({name, "_count"}, match_count, exp_cnt);
    check_output({name, "_first"}, first_pos, exp_first);
  endtask

  initial begin
    int de, me; bit co, early_done;
    logic [CNT_W-1:0] h_cnt; logic [POS_W-1:0] h_first; logic h_found;
    rst_n = 1'b1; start = 1'b0; data = '0; overlap = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_found", found, 0);
    check_output("reset_count", match_count, 0);
    check_output("reset_first", first_pos, 0);
    rst_n = 1'b1;
    cmp_en = 1;

    $display("[TB] basic and overlap scans");
    scan_case("single",   8'b10010000, 1'b0, 1, 3, 5);
    scan_case("ovl_on",   8'b10010010, 1'b1, 2, 3, 5);
    scan_case("ovl_off",  8'b10010010, 1'b0, 1, 3, 5);
    scan_case("no_match", 8'hFF,       1'b0, 0, 0, -1);

    $display("[TB] restart mid-scan");
    apply_stimulus(8'h00, 1'b0);
    early_done = 0;
    @(posedge clk); #1; early_done |= done;
    @(posedge clk); #1; early_done |= done;
    start = 1'b1; data = 8'b00010010; overlap = 1'b0;
    @(posedge clk); #1;
    early_done |= done;
    start = 1'b0;
    wait_done(de, me, co);
    check_output("restart_no_old_done", early_done, 0);
    check_output("restart_done_edge", de, DATA_W);
    check_output("restart_coincide", co, 1);
    check_output("restart_count", match_count, 1);
    check_output("restart_first", first_pos, 0);

    $display("[TB] reset mid-scan");
    apply_stimulus(8'b10010000, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_mp", match_pulse, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_found", found, 0);
    check_output("midrst_count", match_count, 0);
    early_done = 0;
    repeat (2) begin @(posedge clk); #1; early_done |= done; end
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; early_done |= done; end
    check_output("midrst_no_done", early_done, 0);
    scan_case("after_rst", 8'b10010000, 1'b0, 1, 3, 5);

    $display("[TB] idle hold");
    scan_case("pre_idle", 8'b10010010, 1'b1, 2, 3, 5);
    h_found = found; h_cnt = match_count; h_first = first_pos;
    repeat (20) begin
      @(posedge clk); #1;
      data = DATA_W'($urandom); overlap = 1'($urandom);
    end
    check_output("idle_found", found, h_found);
    check_output("idle_count", match_count, h_cnt);
    check_output("idle_first", first_pos, h_first);
    check_output("idle_busy", busy, 0);

    @(negedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
